// File: rtl/board_ram_arbiter_pkg.sv
// snake_pkg: board geometry, cell status codes and arbiter select type.
// in_bounds() is only built when BOUNDS_CHECK_EN is defined.
package snake_pkg;

    localparam int unsigned BOARD_W = 160;
    localparam int unsigned BOARD_H = 120;
    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned ADDR_W  = 15;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY = 2'b00;
    localparam cell_t SNAKE = 2'b01;
    localparam cell_t FOOD  = 2'b10;
    localparam cell_t WALL  = 2'b11;

    typedef enum logic {
        SEL_UPD  = 1'b0,
        SEL_SCAN = 1'b1
    } sel_t;

`ifdef BOUNDS_CHECK_EN
    function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(BOARD_W)) && (y < Y_W'(BOARD_H));
    endfunction
`endif

endpackage

// File: rtl/board_ram_arbiter_if.sv
// Requester and RAM-side signals of the board RAM arbiter.
// slave = arbiter view, master = engines/RAM view.
interface board_ram_arbiter_if;
    import snake_pkg::*;

    logic              upd_req;
    logic              upd_we;
    logic [X_W-1:0]    upd_x;
    logic [Y_W-1:0]    upd_y;
    cell_t             upd_wdata;
    logic              upd_gnt;
    logic              upd_rvalid;
    cell_t             upd_rdata;
    logic              upd_err;

    logic              scan_req;
    logic [X_W-1:0]    scan_x;
    logic [Y_W-1:0]    scan_y;
    logic              scan_gnt;
    logic              scan_rvalid;
    cell_t             scan_rdata;

    logic [ADDR_W-1:0] ram_addr;
    cell_t             ram_data;
    logic              ram_wren;
    cell_t             ram_q;

    modport slave (
        input  upd_req, upd_we, upd_x, upd_y, upd_wdata,
        input  scan_req, scan_x, scan_y, ram_q,
        output upd_gnt, upd_rvalid, upd_rdata, upd_err,
        output scan_gnt, scan_rvalid, scan_rdata,
        output ram_addr, ram_data, ram_wren
    );

    modport master (
        output upd_req, upd_we, upd_x, upd_y, upd_wdata,
        output scan_req, scan_x, scan_y, ram_q,
        input  upd_gnt, upd_rvalid, upd_rdata, upd_err,
        input  scan_gnt, scan_rvalid, scan_rdata,
        input  ram_addr, ram_data, ram_wren
    );

endinterface

// File: rtl/board_ram_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; bit 0 = update engine, bit 1 = scan engine.
module rr_pick2
    import snake_pkg::*;
(
    input  logic [1:0] elig_i,
    input  sel_t       last_sel_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        unique case (elig_i)
            2'b01:   sel_o = 2'b01;
            2'b10:   sel_o = 2'b10;
            2'b11:   sel_o = (last_sel_i == SEL_SCAN) ? 2'b01 : 2'b10;
            default: sel_o = '0;
        endcase
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the board status RAM between the update and scan engines.
// Optional feature macro BOUNDS_CHECK_EN: out-of-range accesses never reach the RAM.
module board_ram_arbiter
    import snake_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    board_ram_arbiter_if.slave bus
);

    logic [1:0]        elig;
    logic [1:0]        sel;
    logic              upd_ok;
    logic              scan_ok;

    sel_t              last_sel_q;
    logic              upd_gnt_q;
    logic              scan_gnt_q;
    logic              upd_rd_q;
    logic              upd_rvalid_q;
    logic              scan_rvalid_q;
    logic              ram_wren_q;
    logic [ADDR_W-1:0] ram_addr_q;
    cell_t             ram_data_q;

    // A requester holding its grant this cycle cannot win again next cycle.
    assign elig = {bus.scan_req & ~scan_gnt_q, bus.upd_req & ~upd_gnt_q};

    rr_pick2 u_pick (
        .elig_i     (elig),
        .last_sel_i (last_sel_q),
        .sel_o      (sel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_sel_q    <= SEL_SCAN;
            upd_gnt_q     <= 1'b0;
            scan_gnt_q    <= 1'b0;
            upd_rd_q      <= 1'b0;
            upd_rvalid_q  <= 1'b0;
            scan_rvalid_q <= 1'b0;
            ram_wren_q    <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= EMPTY;
        end else begin
            upd_gnt_q     <= sel[0];
            scan_gnt_q    <= sel[1];
            upd_rd_q      <= sel[0] & ~bus.upd_we & upd_ok;
            upd_rvalid_q  <= upd_rd_q;
            scan_rvalid_q <= scan_gnt_q;
            ram_wren_q    <= 1'b0;
            if (sel[0]) begin
                last_sel_q <= SEL_UPD;
                if (upd_ok) begin
                    ram_addr_q <= {bus.upd_x, bus.upd_y};
                    ram_data_q <= bus.upd_wdata;
                    ram_wren_q <= bus.upd_we;
                end
            end else if (sel[1]) begin
                last_sel_q <= SEL_SCAN;
                if (scan_ok) begin
                    ram_addr_q <= {bus.scan_x, bus.scan_y};
                end
            end
        end
    end

    assign bus.upd_gnt     = upd_gnt_q;
    assign bus.scan_gnt    = scan_gnt_q;
    assign bus.upd_rvalid  = upd_rvalid_q;
    assign bus.scan_rvalid = scan_rvalid_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.upd_rdata   = upd_rvalid_q ? bus.ram_q : EMPTY;

`ifdef BOUNDS_CHECK_EN
    logic upd_bad_q;
    logic scan_bad_q;
    logic upd_err_q;
    logic scan_wall_q;

    assign upd_ok  = in_bounds(bus.upd_x, bus.upd_y);
    assign scan_ok = in_bounds(bus.scan_x, bus.scan_y);

    // Rejection flags follow the same grant-to-return pipeline as read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_bad_q   <= 1'b0;
            scan_bad_q  <= 1'b0;
            upd_err_q   <= 1'b0;
            scan_wall_q <= 1'b0;
        end else begin
            upd_bad_q   <= sel[0] & ~upd_ok;
            scan_bad_q  <= sel[1] & ~scan_ok;
            upd_err_q   <= upd_bad_q;
            scan_wall_q <= scan_bad_q;
        end
    end

    assign bus.upd_err    = upd_err_q;
    assign bus.scan_rdata = !scan_rvalid_q ? EMPTY : (scan_wall_q ? WALL : bus.ram_q);
`else
    assign upd_ok         = 1'b1;
    assign scan_ok        = 1'b1;
    assign bus.upd_err    = 1'b0;
    assign bus.scan_rdata = scan_rvalid_q ? bus.ram_q : EMPTY;
`endif

endmodule
